// File: rtl/rggen_register_access_arbiter_pkg.sv
// Shared definitions for the register access arbiter: state encoding,
// response codes and pointer arithmetic.
package rggen_register_access_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbiter_state_e;

    localparam logic [1:0] RGGEN_OKAY = 2'b00;

    // Round-robin successor of the requester that just completed.
    function automatic int next_pointer(int current, int requesters);
        return (current >= requesters - 1) ? 0 : current + 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_picker.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping to the lowest set request when none are above it.
module rggen_round_robin_picker #(
    parameter int REQUESTERS = 2
) (
    input  logic [REQUESTERS-1:0]         request,
    input  logic [$clog2(REQUESTERS)-1:0] pointer,
    output logic [REQUESTERS-1:0]         winner,
    output logic [$clog2(REQUESTERS)-1:0] index,
    output logic                          found
);

    logic [REQUESTERS-1:0] eligible_high;
    logic [REQUESTERS-1:0] selected;

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_eligible
            assign eligible_high[gi] = request[gi] && (gi >= int'(pointer));
        end
    endgenerate

    always_comb begin
        winner   = '0;
        index    = '0;
        found    = |request;
        selected = (|eligible_high) ? eligible_high : request;
        // Scan downward so the lowest set bit is the final assignment.
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (selected[i]) begin
                winner = REQUESTERS'(1) << i;
                index  = $clog2(REQUESTERS)'(i);
            end
        end
    end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-block bus between several hosts;
// the winning request is latched, held until downstream ready, then routed back.
module rggen_register_access_arbiter
    import rggen_register_access_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [REQUESTERS-1:0]             i_request_valid,
    input  logic [2*REQUESTERS-1:0]           i_request_access,
    input  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_request_address,
    input  logic [BUS_WIDTH*REQUESTERS-1:0]   i_request_write_data,
    input  logic [BUS_WIDTH/8*REQUESTERS-1:0] i_request_strobe,
    output logic [REQUESTERS-1:0]             o_request_ready,
    output logic [1:0]                        o_request_status,
    output logic [BUS_WIDTH-1:0]              o_request_read_data,
    output logic [REQUESTERS-1:0]             o_grant,
    output logic                              o_register_valid,
    output logic [1:0]                        o_register_access,
    output logic [ADDRESS_WIDTH-1:0]          o_register_address,
    output logic [BUS_WIDTH-1:0]              o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]            o_register_strobe,
    input  logic                              i_register_ready,
    input  logic [1:0]                        i_register_status,
    input  logic [BUS_WIDTH-1:0]              i_register_read_data
);

    localparam int INDEX_WIDTH  = $clog2(REQUESTERS);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;

    arbiter_state_e           state_reg;
    arbiter_state_e           state_next;
    logic [INDEX_WIDTH-1:0]   pointer_reg;
    logic [INDEX_WIDTH-1:0]   index_reg;
    logic [REQUESTERS-1:0]    grant_reg;
    logic [1:0]               access_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic [BUS_WIDTH-1:0]     write_data_reg;
    logic [STROBE_WIDTH-1:0]  strobe_reg;

    logic [REQUESTERS-1:0]    pick_winner;
    logic [INDEX_WIDTH-1:0]   pick_index;
    logic                     pick_found;
    logic                     start;
    logic                     finish;

    logic [1:0]               access_array     [REQUESTERS];
    logic [ADDRESS_WIDTH-1:0] address_array    [REQUESTERS];
    logic [BUS_WIDTH-1:0]     write_data_array [REQUESTERS];
    logic [STROBE_WIDTH-1:0]  strobe_array     [REQUESTERS];

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign access_array[gi]     = i_request_access[2*gi +: 2];
            assign address_array[gi]    = i_request_address[ADDRESS_WIDTH*gi +: ADDRESS_WIDTH];
            assign write_data_array[gi] = i_request_write_data[BUS_WIDTH*gi +: BUS_WIDTH];
            assign strobe_array[gi]     = i_request_strobe[STROBE_WIDTH*gi +: STROBE_WIDTH];
        end
    endgenerate

    rggen_round_robin_picker #(
        .REQUESTERS (REQUESTERS)
    ) u_picker (
        .request (i_request_valid),
        .pointer (pointer_reg),
        .winner  (pick_winner),
        .index   (pick_index),
        .found   (pick_found)
    );

    assign start  = (state_reg == IDLE) && pick_found;
    assign finish = (state_reg == BUSY) && i_register_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = BUSY;
            BUSY:    if (i_register_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion is combinational so the owner sees ready in the same cycle.
    always_comb begin
        o_register_valid    = 1'b0;
        o_request_ready     = '0;
        o_request_status    = RGGEN_OKAY;
        o_request_read_data = '0;
        if (state_reg == BUSY) begin
            o_register_valid = 1'b1;
            if (i_register_ready) begin
                o_request_ready     = grant_reg;
                o_request_status    = i_register_status;
                o_request_read_data = i_register_read_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pointer_reg    <= '0;
            index_reg      <= '0;
            grant_reg      <= '0;
            access_reg     <= '0;
            address_reg    <= '0;
            write_data_reg <= '0;
            strobe_reg     <= '0;
        end else if (start) begin
            grant_reg      <= pick_winner;
            index_reg      <= pick_index;
            access_reg     <= access_array[pick_index];
            address_reg    <= address_array[pick_index];
            write_data_reg <= write_data_array[pick_index];
            strobe_reg     <= strobe_array[pick_index];
        end else if (finish) begin
            grant_reg   <= '0;
            pointer_reg <= INDEX_WIDTH'(next_pointer(int'(index_reg), REQUESTERS));
        end
    end

    assign o_grant               = grant_reg;
    assign o_register_access     = access_reg;
    assign o_register_address    = address_reg;
    assign o_register_write_data = write_data_reg;
    assign o_register_strobe     = strobe_reg;

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Scoreboard bench: a two-requester and a three-requester arbiter, each with a
// downstream responder model, a requester model and a completion monitor.
module tb_rggen_register_access_arbiter;

    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = 4;
    localparam logic [1:0] ACC_READ  = 2'b10;
    localparam logic [1:0] ACC_WRITE = 2'b11;

    typedef struct {
        int          req;
        logic [1:0]  access;
        logic [AW-1:0] address;
        logic [BW-1:0] write_data;
        logic [SW-1:0] strobe;
        logic [1:0]  status;
        logic [BW-1:0] read_data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    txn_t exp2[$];
    txn_t exp3[$];
    int done2 = 0;
    int done3 = 0;

    // two-requester instance
    logic          rst_n2;
    logic [1:0]    valid2;
    logic [3:0]    access2;
    logic [15:0]   address2;
    logic [63:0]   wdata2;
    logic [7:0]    strobe2;
    logic [1:0]    ready_o2;
    logic [1:0]    status_o2;
    logic [BW-1:0] rdata_o2;
    logic [1:0]    grant2;
    logic          reg_valid2;
    logic [1:0]    reg_access2;
    logic [AW-1:0] reg_address2;
    logic [BW-1:0] reg_wdata2;
    logic [SW-1:0] reg_strobe2;
    logic          reg_ready2;
    logic [1:0]    reg_status2;
    logic [BW-1:0] reg_rdata2;
    int            lat2 = 1;
    logic          poke2 = 1'b0;
    logic          auto_clear2 = 1'b1;
    logic [1:0]    rsp_status2 = 2'b00;
    logic [BW-1:0] rsp_data2 = '0;

    // three-requester instance
    logic          rst_n3;
    logic [2:0]    valid3;
    logic [5:0]    access3;
    logic [23:0]   address3;
    logic [95:0]   wdata3;
    logic [11:0]   strobe3;
    logic [2:0]    ready_o3;
    logic [1:0]    status_o3;
    logic [BW-1:0] rdata_o3;
    logic [2:0]    grant3;
    logic          reg_valid3;
    logic [1:0]    reg_access3;
    logic [AW-1:0] reg_address3;
    logic [BW-1:0] reg_wdata3;
    logic [SW-1:0] reg_strobe3;
    logic          reg_ready3;
    logic [1:0]    reg_status3;
    logic [BW-1:0] reg_rdata3;
    int            lat3 = 0;
    logic          auto_clear3 = 1'b1;
    logic [1:0]    rsp_status3 = 2'b01;
    logic [BW-1:0] rsp_data3 = 32'h00C0FFEE;

    rggen_register_access_arbiter #(
        .REQUESTERS(2), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst_n2),
        .i_request_valid(valid2), .i_request_access(access2),
        .i_request_address(address2), .i_request_write_data(wdata2),
        .i_request_strobe(strobe2), .o_request_ready(ready_o2),
        .o_request_status(status_o2), .o_request_read_data(rdata_o2),
        .o_grant(grant2), .o_register_valid(reg_valid2),
        .o_register_access(reg_access2), .o_register_address(reg_address2),
        .o_register_write_data(reg_wdata2), .o_register_strobe(reg_strobe2),
        .i_register_ready(reg_ready2), .i_register_status(reg_status2),
        .i_register_read_data(reg_rdata2)
    );

    rggen_register_access_arbiter #(
        .REQUESTERS(3), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
    ) dut3 (
        .i_clk(clk), .i_rst_n(rst_n3),
        .i_request_valid(valid3), .i_request_access(access3),
        .i_request_address(address3), .i_request_write_data(wdata3),
        .i_request_strobe(strobe3), .o_request_ready(ready_o3),
        .o_request_status(status_o3), .o_request_read_data(rdata_o3),
        .o_grant(grant3), .o_register_valid(reg_valid3),
        .o_register_access(reg_access3), .o_register_address(reg_address3),
        .o_register_write_data(reg_wdata3), .o_register_strobe(reg_strobe3),
        .i_register_ready(reg_ready3), .i_register_status(reg_status3),
        .i_register_read_data(reg_rdata3)
    );

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue2(int n, logic [1:0] acc, logic [AW-1:0] addr, logic [BW-1:0] wd, logic [SW-1:0] st);
        access2[2*n +: 2]    = acc;
        address2[AW*n +: AW] = addr;
        wdata2[BW*n +: BW]   = wd;
        strobe2[SW*n +: SW]  = st;
        valid2[n]            = 1'b1;
    endtask

    task automatic issue3(int n, logic [1:0] acc, logic [AW-1:0] addr, logic [BW-1:0] wd, logic [SW-1:0] st);
        access3[2*n +: 2]    = acc;
        address3[AW*n +: AW] = addr;
        wdata3[BW*n +: BW]   = wd;
        strobe3[SW*n +: SW]  = st;
        valid3[n]            = 1'b1;
    endtask

    task automatic expect2(int n, logic [1:0] acc, logic [AW-1:0] addr, logic [BW-1:0] wd,
                           logic [SW-1:0] st, logic [1:0] rs, logic [BW-1:0] rd);
        txn_t t;
        t.req = n; t.access = acc; t.address = addr; t.write_data = wd;
        t.strobe = st; t.status = rs; t.read_data = rd;
        exp2.push_back(t);
    endtask

    task automatic expect3(int n, logic [1:0] acc, logic [AW-1:0] addr, logic [BW-1:0] wd,
                           logic [SW-1:0] st, logic [1:0] rs, logic [BW-1:0] rd);
        txn_t t;
        t.req = n; t.access = acc; t.address = addr; t.write_data = wd;
        t.strobe = st; t.status = rs; t.read_data = rd;
        exp3.push_back(t);
    endtask

    task automatic wait_done2(int target, int budget);
        for (int i = 0; i < budget; i++) begin
            if (done2 >= target) break;
            @(posedge clk);
        end
        check("d2_completions", 64'(done2), 64'(target));
    endtask

    task automatic wait_done3(int target, int budget);
        for (int i = 0; i < budget; i++) begin
            if (done3 >= target) break;
            @(posedge clk);
        end
        check("d3_completions", 64'(done3), 64'(target));
    endtask

    // Downstream register block models: ready after lat cycles of valid,
    // garbage on status/data whenever ready is low.
    initial begin
        int cnt;
        cnt = 0;
        reg_ready2 = 1'b0; reg_status2 = 2'b11; reg_rdata2 = 32'hDEADBEEF;
        forever begin
            @(posedge clk); #1;
            if (reg_valid2 && cnt >= lat2) begin
                reg_ready2 = 1'b1; reg_status2 = rsp_status2; reg_rdata2 = rsp_data2; cnt = 0;
            end else begin
                reg_ready2 = poke2; reg_status2 = 2'b11; reg_rdata2 = 32'hDEADBEEF;
                cnt = reg_valid2 ? cnt + 1 : 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        reg_ready3 = 1'b0; reg_status3 = 2'b11; reg_rdata3 = 32'hDEADBEEF;
        forever begin
            @(posedge clk); #1;
            if (reg_valid3 && cnt >= lat3) begin
                reg_ready3 = 1'b1; reg_status3 = rsp_status3; reg_rdata3 = rsp_data3; cnt = 0;
            end else begin
                reg_ready3 = 1'b0; reg_status3 = 2'b11; reg_rdata3 = 32'hDEADBEEF;
                cnt = reg_valid3 ? cnt + 1 : 0;
            end
        end
    end

    // Requester models: drop valid in the cycle after the ready pulse.
    initial begin
        logic [1:0] seen;
        forever begin
            @(negedge clk);
            seen = ready_o2;
            if (auto_clear2 && seen != 0) begin
                @(posedge clk); #2;
                valid2 = valid2 & ~seen;
            end
        end
    end

    initial begin
        logic [2:0] seen;
        forever begin
            @(negedge clk);
            seen = ready_o3;
            if (auto_clear3 && seen != 0) begin
                @(posedge clk); #2;
                valid3 = valid3 & ~seen;
            end
        end
    end

    // Completion monitors
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (ready_o2 != 0) begin
                if (exp2.size() == 0) begin
                    check("d2_unexpected_ready", 64'(ready_o2), 64'd0);
                end else begin
                    t = exp2.pop_front();
                    $display("d2 txn: req%0d addr=%0h status=%0h rdata=%0h", t.req, reg_address2, status_o2, rdata_o2);
                    check("d2_ready_owner", 64'(ready_o2), 64'(1) << t.req);
                    check("d2_grant", 64'(grant2), 64'(1) << t.req);
                    check("d2_access", 64'(reg_access2), 64'(t.access));
                    check("d2_address", 64'(reg_address2), 64'(t.address));
                    check("d2_write_data", 64'(reg_wdata2), 64'(t.write_data));
                    check("d2_strobe", 64'(reg_strobe2), 64'(t.strobe));
                    check("d2_status", 64'(status_o2), 64'(t.status));
                    check("d2_read_data", 64'(rdata_o2), 64'(t.read_data));
                end
                done2++;
            end else begin
                check("d2_idle_response_zero", {30'd0, status_o2, rdata_o2}, 64'd0);
            end
        end
    end

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (ready_o3 != 0) begin
                if (exp3.size() == 0) begin
                    check("d3_unexpected_ready", 64'(ready_o3), 64'd0);
                end else begin
                    t = exp3.pop_front();
                    $display("d3 txn: req%0d addr=%0h status=%0h rdata=%0h", t.req, reg_address3, status_o3, rdata_o3);
                    check("d3_ready_owner", 64'(ready_o3), 64'(1) << t.req);
                    check("d3_grant", 64'(grant3), 64'(1) << t.req);
                    check("d3_access", 64'(reg_access3), 64'(t.access));
                    check("d3_address", 64'(reg_address3), 64'(t.address));
                    check("d3_write_data", 64'(reg_wdata3), 64'(t.write_data));
                    check("d3_strobe", 64'(reg_strobe3), 64'(t.strobe));
                    check("d3_status", 64'(status_o3), 64'(t.status));
                    check("d3_read_data", 64'(rdata_o3), 64'(t.read_data));
                end
                done3++;
            end else begin
                check("d3_idle_response_zero", {30'd0, status_o3, rdata_o3}, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n2 = 1'b0; rst_n3 = 1'b0;
        valid2 = '0; access2 = '0; address2 = '0; wdata2 = '0; strobe2 = '0;
        valid3 = '0; access3 = '0; address3 = '0; wdata3 = '0; strobe3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("d2_reset_ctrl", {reg_valid2, grant2, reg_access2, reg_address2, reg_strobe2, ready_o2}, 64'd0);
        check("d2_reset_wdata", 64'(reg_wdata2), 64'd0);
        check("d3_reset_ctrl", {reg_valid3, grant3, reg_access3, reg_address3, reg_strobe3, ready_o3}, 64'd0);
        check("d3_reset_wdata", 64'(reg_wdata3), 64'd0);
        rst_n2 = 1'b1; rst_n3 = 1'b1;

        // Single write from req0, downstream ready in cycle 2
        cyc();
        lat2 = 1; rsp_status2 = 2'b00; rsp_data2 = 32'h12345678;
        issue2(0, ACC_WRITE, 8'h10, 32'hA5A5A5A5, 4'hF);
        expect2(0, ACC_WRITE, 8'h10, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h12345678);
        @(negedge clk);
        check("t1_c0_valid_grant", {reg_valid2, grant2}, 64'd0);
        @(negedge clk);
        check("t1_c1_valid_grant_ready", {reg_valid2, grant2, ready_o2}, {59'd0, 1'b1, 2'b01, 2'b00});
        @(negedge clk);
        check("t1_c2_valid_grant_ready", {reg_valid2, grant2, ready_o2}, {59'd0, 1'b1, 2'b01, 2'b01});
        @(negedge clk);
        check("t1_c3_valid_grant_ready", {reg_valid2, grant2, ready_o2}, 64'd0);
        wait_done2(1, 10);

        // Read from req1 (pointer now 1), exact data routed back
        cyc(); cyc();
        lat2 = 2;
        issue2(1, ACC_READ, 8'h30, 32'h0, 4'h0);
        expect2(1, ACC_READ, 8'h30, 32'h0, 4'h0, 2'b00, 32'h12345678);
        wait_done2(2, 20);

        // Simultaneous requests with pointer back at 0, req1 address changes while BUSY
        cyc(); cyc();
        lat2 = 1; rsp_status2 = 2'b01; rsp_data2 = 32'hCAFEF00D;
        issue2(0, ACC_WRITE, 8'h40, 32'h11111111, 4'h3);
        issue2(1, ACC_WRITE, 8'h20, 32'h22222222, 4'hC);
        expect2(0, ACC_WRITE, 8'h40, 32'h11111111, 4'h3, 2'b01, 32'hCAFEF00D);
        expect2(1, ACC_WRITE, 8'h20, 32'h22222222, 4'hC, 2'b01, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        check("t3_c1_grant", 64'(grant2), 64'h1);
        @(negedge clk);
        check("t3_c2_ready", 64'(ready_o2), 64'h1);
        @(negedge clk);
        check("t3_c3_idle_gap", {reg_valid2, grant2}, 64'd0);
        @(negedge clk);
        check("t3_c4_grant", 64'(grant2), 64'h2);
        check("t3_c4_address", 64'(reg_address2), 64'h20);
        address2[15:8] = 8'h24;
        @(negedge clk);
        check("t3_c5_address_frozen", 64'(reg_address2), 64'h20);
        check("t3_c5_ready", 64'(ready_o2), 64'h2);
        wait_done2(4, 10);

        // Pointer returned to 0: req0 wins again
        cyc(); cyc();
        lat2 = 0; rsp_status2 = 2'b10; rsp_data2 = 32'h0BADF00D;
        issue2(0, ACC_READ, 8'h50, 32'h0, 4'h0);
        issue2(1, ACC_WRITE, 8'h24, 32'h33333333, 4'hF);
        expect2(0, ACC_READ, 8'h50, 32'h0, 4'h0, 2'b10, 32'h0BADF00D);
        expect2(1, ACC_WRITE, 8'h24, 32'h33333333, 4'hF, 2'b10, 32'h0BADF00D);
        wait_done2(6, 20);

        // Requester drops valid before ready; transaction still completes
        cyc(); cyc();
        lat2 = 3;
        issue2(0, ACC_READ, 8'h55, 32'h0, 4'h0);
        expect2(0, ACC_READ, 8'h55, 32'h0, 4'h0, 2'b10, 32'h0BADF00D);
        @(negedge clk);
        @(negedge clk);
        valid2[0] = 1'b0;
        wait_done2(7, 20);

        // Downstream ready while IDLE has no effect
        cyc(); cyc();
        poke2 = 1'b1;
        @(negedge clk); @(negedge clk);
        check("t6_idle_poke", {reg_valid2, grant2, ready_o2}, 64'd0);
        poke2 = 1'b0;

        // Fairness with three requesters held continuously
        cyc();
        lat3 = 0; auto_clear3 = 1'b0;
        for (int n = 0; n < 3; n++)
            issue3(n, ACC_WRITE, 8'(8'h60 + n), 32'hF0000000 | 32'(n), 4'hF);
        for (int k = 0; k < 6; k++)
            expect3(k % 3, ACC_WRITE, 8'(8'h60 + k % 3), 32'hF0000000 | 32'(k % 3), 4'hF, 2'b01, 32'h00C0FFEE);
        wait_done3(6, 40);
        #1;
        valid3 = '0;
        auto_clear3 = 1'b1;

        // Reset during BUSY: first move pointer to 1, then interrupt req1
        cyc(); cyc();
        issue3(0, ACC_WRITE, 8'h70, 32'h70707070, 4'hF);
        expect3(0, ACC_WRITE, 8'h70, 32'h70707070, 4'hF, 2'b01, 32'h00C0FFEE);
        wait_done3(7, 10);
        cyc(); cyc();
        lat3 = 6;
        issue3(1, ACC_WRITE, 8'h71, 32'h71717171, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("t8_busy_before_reset", {reg_valid3, grant3}, {60'd0, 1'b1, 3'b010});
        @(negedge clk);
        #2;
        rst_n3 = 1'b0;
        #1;
        check("t8_async_drop", {reg_valid3, grant3, ready_o3}, 64'd0);
        check("t8_fields_cleared", 64'(reg_address3), 64'd0);
        lat3 = 0;
        issue3(0, ACC_READ, 8'h72, 32'h0, 4'h0);
        expect3(0, ACC_READ, 8'h72, 32'h0, 4'h0, 2'b01, 32'h00C0FFEE);
        expect3(1, ACC_WRITE, 8'h71, 32'h71717171, 4'hF, 2'b01, 32'h00C0FFEE);
        @(negedge clk);
        rst_n3 = 1'b1;
        wait_done3(9, 20);

        cyc(); cyc();
        check("d2_scoreboard_empty", 64'(exp2.size()), 64'd0);
        check("d3_scoreboard_empty", 64'(exp3.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
